// File: rtl/date_set_ctrl.sv
// date_set_ctrl: user date-entry controller for the century clock.
// Edits year/month/day in BCD from the current calendar date, clamps the
// day to the edited month and loads the binary date over valid/ready.
// Optional feature macro: DATE_SET_LEAP_EN (February has 29 days in years
// divisible by 4; year 00 counts as leap).
module date_set_ctrl #(
    parameter int unsigned SEED_YEAR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       inc,
    input  logic       dec,
    input  logic       next,
    input  logic       abort,
    input  logic [3:0] cur_day_1,
    input  logic [1:0] cur_day_10,
    input  logic [3:0] cur_mon_1,
    input  logic [1:0] cur_mon_10,
    input  logic [3:0] cur_year_1,
    input  logic [3:0] cur_year_10,
    output logic [3:0] edit_day_1,
    output logic [1:0] edit_day_10,
    output logic [3:0] edit_mon_1,
    output logic [1:0] edit_mon_10,
    output logic [3:0] edit_year_1,
    output logic [3:0] edit_year_10,
    output logic [1:0] field,
    output logic       load_valid,
    input  logic       load_ready,
    output logic [4:0] load_day,
    output logic [3:0] load_mon,
    output logic [6:0] load_year
);

    typedef enum logic [2:0] {IDLE, YEAR, MON, DAY, LOAD} state_t;

    localparam logic [6:0] SEED_BIN = 7'(SEED_YEAR);
    localparam logic [7:0] SEED_BCD = {4'(SEED_BIN / 7'd10), 4'(SEED_BIN % 7'd10)};

    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        bcd2bin = 7'(tens) * 7'd10 + 7'(ones);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        bin2bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [6:0] month_max(input logic [6:0] mon, input logic leap);
        case (mon)
            7'd2:                    month_max = leap ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11: month_max = 7'd30;
            default:                 month_max = 7'd31;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [6:0] day_bin, mon_bin, year_bin;
    logic [6:0] day_d, mon_d, year_d;
    logic [6:0] seed_day, seed_mon, seed_year;
    logic [6:0] max_cur;
    logic [7:0] day_bcd, mon_bcd, year_bcd;
    logic [1:0] field_d;
    logic       leap;
    logic       step;

    assign day_bin  = bcd2bin({2'b00, edit_day_10}, edit_day_1);
    assign mon_bin  = bcd2bin({2'b00, edit_mon_10}, edit_mon_1);
    assign year_bin = bcd2bin(edit_year_10, edit_year_1);

`ifdef DATE_SET_LEAP_EN
    assign leap = (year_bin[1:0] == 2'b00);
`else
    assign leap = 1'b0;
`endif

    assign max_cur = month_max(mon_bin, leap);
    assign step    = inc ^ dec;

    // Seed values from the current date, replacing any illegal field
    always_comb begin
        seed_year = bcd2bin(cur_year_10, cur_year_1);
        if (cur_year_10 > 4'd9 || cur_year_1 > 4'd9) seed_year = SEED_BIN;
        seed_mon = bcd2bin({2'b00, cur_mon_10}, cur_mon_1);
        if (cur_mon_1 > 4'd9 || seed_mon == 7'd0 || seed_mon > 7'd12) seed_mon = 7'd1;
        seed_day = bcd2bin({2'b00, cur_day_10}, cur_day_1);
        if (cur_day_1 > 4'd9 || seed_day == 7'd0 || seed_day > 7'd31) seed_day = 7'd1;
    end

    // Next state, field edits (abort > next > inc/dec) and day clamp
    always_comb begin
        state_d = state_q;
        day_d   = day_bin;
        mon_d   = mon_bin;
        year_d  = year_bin;
        case (state_q)
            IDLE: begin
                if (set_req) begin
                    state_d = YEAR;
                    year_d  = seed_year;
                    mon_d   = seed_mon;
                    day_d   = seed_day;
                end
            end
            YEAR: begin
                if (abort)     state_d = IDLE;
                else if (next) state_d = MON;
                else if (step) begin
                    if (inc) year_d = (year_bin >= 7'd99) ? 7'd0 : year_bin + 7'd1;
                    else     year_d = (year_bin == 7'd0) ? 7'd99 : year_bin - 7'd1;
                end
            end
            MON: begin
                if (abort)     state_d = IDLE;
                else if (next) state_d = DAY;
                else if (step) begin
                    if (inc) mon_d = (mon_bin >= 7'd12) ? 7'd1 : mon_bin + 7'd1;
                    else     mon_d = (mon_bin <= 7'd1) ? 7'd12 : mon_bin - 7'd1;
                end
            end
            DAY: begin
                if (abort)     state_d = IDLE;
                else if (next) state_d = LOAD;
                else if (step) begin
                    if (inc) day_d = (day_bin >= max_cur) ? 7'd1 : day_bin + 7'd1;
                    else     day_d = (day_bin <= 7'd1) ? max_cur : day_bin - 7'd1;
                end
            end
            LOAD: begin
                if (load_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Leaving YEAR or MON re-fits the day to the edited month and year
        if ((state_q == YEAR || state_q == MON) && state_d != state_q && day_d > max_cur)
            day_d = max_cur;
    end

    // Output encodings derived from the next state and next edit values
    always_comb begin
        day_bcd  = bin2bcd(day_d);
        mon_bcd  = bin2bcd(mon_d);
        year_bcd = bin2bcd(year_d);
        case (state_d)
            YEAR:    field_d = 2'b01;
            MON:     field_d = 2'b10;
            DAY:     field_d = 2'b11;
            default: field_d = 2'b00;
        endcase
    end

    // State, edit registers and registered load outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            edit_day_10  <= 2'd0;
            edit_day_1   <= 4'd1;
            edit_mon_10  <= 2'd0;
            edit_mon_1   <= 4'd1;
            edit_year_10 <= SEED_BCD[7:4];
            edit_year_1  <= SEED_BCD[3:0];
            field        <= 2'b00;
            load_valid   <= 1'b0;
            load_day     <= 5'd1;
            load_mon     <= 4'd1;
            load_year    <= SEED_BIN;
        end else begin
            state_q      <= state_d;
            edit_day_10  <= 2'(day_bcd[7:4]);
            edit_day_1   <= day_bcd[3:0];
            edit_mon_10  <= 2'(mon_bcd[7:4]);
            edit_mon_1   <= mon_bcd[3:0];
            edit_year_10 <= year_bcd[7:4];
            edit_year_1  <= year_bcd[3:0];
            field        <= field_d;
            load_valid   <= (state_d == LOAD);
            load_day     <= 5'(day_d);
            load_mon     <= 4'(mon_d);
            load_year    <= year_d;
        end
    end

endmodule

// File: doc/date_set_ctrl.md
# date_set_ctrl

User date-entry controller for the century clock, the write-side counterpart of the day/month/year calendar counter. It accepts button pulses to edit year, month and day in BCD, seeded from the counter's current BCD outputs. It clamps and wraps each field to a legal calendar date, then converts the result to binary and hands it to the calendar counter over a valid/ready load handshake.

## Interface
Parameters:
- `SEED_YEAR`, default 0: binary year loaded into the edit register on reset and when a seeded year is invalid.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `set_req`  in  1  one-cycle pulse: enter set mode
- `inc` / `dec`  in  1 each  one-cycle pulse: step the active field up or down
- `next`  in  1  one-cycle pulse: advance to the next field, or commit from the day field
- `abort`  in  1  one-cycle pulse: leave set mode without loading
- `cur_day_1` [3:0], `cur_day_10` [1:0], `cur_mon_1` [3:0], `cur_mon_10` [1:0], `cur_year_1` [3:0], `cur_year_10` [3:0]  in  current date in BCD, used as the seed
- `edit_day_1` [3:0], `edit_day_10` [1:0], `edit_mon_1` [3:0], `edit_mon_10` [1:0], `edit_year_1` [3:0], `edit_year_10` [3:0]  out  date being edited, BCD
- `field`  out  2  active field: 00 none, 01 year, 10 month, 11 day
- `load_valid`  out  1  load request to the calendar counter
- `load_ready`  in  1  calendar counter accepts the load
- `load_day` [4:0], `load_mon` [3:0], `load_year` [6:0]  out  binary date, stable while `load_valid` is high

## Operation
- FSM states: IDLE, YEAR, MON, DAY, LOAD.
- **IDLE:**
  - `set_req` captures the `cur_*` inputs into the edit registers and moves to YEAR.
  - Seed validation is per field. Any BCD digit above 9, month 00 or above 12, or day 00 or above 31 replaces that field with 01 (day or month) or `SEED_YEAR` (year).
- **YEAR / MON / DAY:**
  - `inc` increments the active field in BCD; `dec` decrements it.
  - Year wraps 99→00 and 00→99.
  - Month wraps 12→01 and 01→12.
  - Day wraps max→01 and 01→max, where max = days in the edited month: 31/30, and 28 for February (see Configuration).
- **`next`:** YEAR→MON, MON→DAY, DAY→LOAD.
- **Day clamp on entering DAY:** if the edited day exceeds max for the edited month and year, it is set to max.
- **Day clamp on leaving YEAR or MON:** the same clamp is reapplied.
- **Priority per cycle:** `abort` > `next` > `inc`/`dec`. `inc` and `dec` asserted together: no change.
- **`abort`:** in YEAR/MON/DAY, returns to IDLE; edit registers are kept and nothing is loaded. In LOAD it is ignored.
- **`set_req`:** ignored outside IDLE.
- **LOAD:**
  - `load_valid` is high.
  - `load_day` = 10·d10 + d1; `load_mon` and `load_year` are converted the same way.
  - On `load_valid && load_ready`: return to IDLE.
- `field` follows the state: LOAD and IDLE both drive 00.

## Timing
- **Reset values:**
  - `edit_day` = 01, `edit_mon` = 01, `edit_year` = `SEED_YEAR` in BCD.
  - `field` = 00, `load_valid` = 0.
  - `load_*` outputs = the binary value of the reset edit registers.
- **Latencies:**
  - `set_req` at cycle N → `field` = 01 and seeded `edit_*` at N+1.
  - `inc`/`dec` at N → updated `edit_*` at N+1. Back-to-back pulses each step once.
  - `next` in DAY at N → `load_valid` = 1 at N+1, with `load_*` already valid and registered.
- **Handshake:**
  - `load_valid` stays high, with `load_*` unchanged, until sampled with `load_ready` = 1.
  - `load_valid` goes low the following cycle.
  - `load_ready` high while `load_valid` is low has no effect.
- **Reset mid-operation:** any state goes to IDLE immediately, with all outputs at reset values.

## Configuration
- Macro: `DATE_SET_LEAP_EN`.
- **Defined:** February max is 29 when the edited year is divisible by 4 (00 counts as leap for 2000–2099), otherwise 28.
- **Undefined:** February max is always 28. `edit_year` does not affect the day maximum.

## Test plan
- Reset, then `set_req` with `cur` = 15-08-24 → `field` = 01 and edit = 15-08-24 next cycle. Then `next`, `next`, `next` → `load_valid` with `load_day` = 15, `load_mon` = 8, `load_year` = 24. Hold `load_ready` low 3 cycles, then high 1 cycle → IDLE and `load_valid` = 0.
- **Wraps:**
  - Year 99 + `inc` → 00.
  - Month 01 + `dec` → 12.
  - Day 31 in month 12 + `inc` → 01.
  - Day 01 in month 04 + `dec` → 30.
- Seed 31-01-23, set month to 02, `next` → day clamps to 28. With `DATE_SET_LEAP_EN` and year 24 → 29. Without the macro and year 24 → 28.
- **Invalid seed:** `cur_mon` = 1_5, `cur_day_1` = 4'hC → month 01, day 01. Year seeded normally.
- **Concurrent pulses:**
  - `inc` + `dec` together → no change.
  - `next` + `inc` → field advances, value unchanged.
  - `abort` in MON → IDLE, `load_valid` never asserts.
  - `abort` in LOAD → ignored.
- **Reset during LOAD** with `load_valid` high → `load_valid` = 0 and `field` = 00 immediately. A later `set_req` works normally.
